// File: rtl/dac_cmd_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : dac_cmd_arbiter                                              |
// | Description : Round-robin arbiter sharing one SPI DAC serializer between   |
// |               NUM_REQ requesters; formats {CMD_WR, ch, code} words, drives |
// |               the start/busy/done handshake and enforces a settle gap.     |
// |               Optional power-up init frames: define DAC_INIT_SEQ_EN.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module dac_cmd_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CH_W        = 4,
  parameter int unsigned CODE_W      = 16,
  parameter logic [3:0]  CMD_WR      = 4'b0011,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       dac_clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*CH_W-1:0]    req_ch,
  input  logic [NUM_REQ*CODE_W-1:0]  req_code,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [23:0]                spi_word_o,
  output logic                       spi_start_o,
  input  logic                       spi_busy_i,
  input  logic                       spi_done_i,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned c_ptr_w   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned c_sum_w   = c_ptr_w + 1;
  localparam int unsigned c_cnt_max = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int unsigned c_cnt_w   = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_to_last     = c_cnt_w'(TIMEOUT_CYC - 1);
  localparam logic [c_cnt_w-1:0] c_settle_last = c_cnt_w'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [c_sum_w-1:0] c_num_req     = c_sum_w'(NUM_REQ);
  localparam logic [c_ptr_w-1:0] c_last_req    = c_ptr_w'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_SETTLE    = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [c_ptr_w-1:0]   r_ptr;
  logic [c_ptr_w-1:0]   w_ptr_nxt;
  logic [23:0]          r_word;
  logic [23:0]          w_word_d;
  logic                 w_load;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 w_cnt_clr;
  logic                 r_err;
  logic                 r_busy;
  logic                 w_busy_nxt;
  logic                 w_timeout;
  logic                 w_start;
  logic [NUM_REQ-1:0]   w_ready;

  logic                 w_any;
  logic [c_ptr_w-1:0]   w_win;
  logic [c_sum_w-1:0]   w_sum;
  logic [c_ptr_w-1:0]   w_cand;
  logic [CH_W-1:0]      w_ch;
  logic [CODE_W-1:0]    w_code;

  logic                 w_init_active;
  logic [23:0]          w_init_word;
  logic                 c_busy_rst;

  // First requester at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + c_sum_w'(k);
      if (w_sum >= c_num_req) begin
        w_sum = w_sum - c_num_req;
      end
      w_cand = w_sum[c_ptr_w-1:0];
      if (!w_any && req_valid[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  always_comb begin
    w_ch   = '0;
    w_code = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == c_ptr_w'(i)) begin
        w_ch   = req_ch[i*CH_W +: CH_W];
        w_code = req_code[i*CODE_W +: CODE_W];
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_ptr_nxt = r_ptr;
    w_word_d  = r_word;
    w_load    = 1'b0;
    w_cnt_clr = 1'b0;
    w_timeout = 1'b0;
    w_start   = 1'b0;
    w_ready   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_init_active) begin
          w_load   = 1'b1;
          w_word_d = w_init_word;
          w_next   = S_LAUNCH;
        end else if (w_any) begin
          w_ready[w_win] = 1'b1;
          w_load         = 1'b1;
          w_word_d       = {CMD_WR, w_ch, w_code};
          w_ptr_nxt      = (w_win == c_last_req) ? '0 : w_win + c_ptr_w'(1);
          w_next         = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!spi_busy_i) begin
          w_start   = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (spi_done_i) begin
          w_cnt_clr = 1'b1;
          w_next    = (SETTLE_CYC == 0) ? S_IDLE : S_SETTLE;
        end else if (r_cnt == c_to_last) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == c_settle_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef DAC_INIT_SEQ_EN
  // Two fixed power-up frames (software reset, internal reference on)
  logic [1:0] r_init_left;
  logic [1:0] w_init_left_nxt;
  logic       w_frame_end;

  assign w_frame_end = ((r_state == S_SETTLE) && (r_cnt == c_settle_last)) ||
                       ((r_state == S_WAIT_DONE) && spi_done_i && (SETTLE_CYC == 0));

  always_comb begin
    w_init_left_nxt = r_init_left;
    if (w_timeout) begin
      w_init_left_nxt = 2'd0;
    end else if (w_frame_end && (r_init_left != 2'd0)) begin
      w_init_left_nxt = r_init_left - 2'd1;
    end
  end

  assign w_init_active = (r_init_left != 2'd0);
  assign w_init_word   = (r_init_left == 2'd2) ? 24'h700000 : 24'h800001;
  assign w_busy_nxt    = (w_next != S_IDLE) || (w_init_left_nxt != 2'd0);
  assign c_busy_rst    = 1'b1;

  always_ff @(posedge dac_clk) begin
    if (!rst_n) begin
      r_init_left <= 2'd2;
    end else begin
      r_init_left <= w_init_left_nxt;
    end
  end
`else
  assign w_init_active = 1'b0;
  assign w_init_word   = '0;
  assign w_busy_nxt    = (w_next != S_IDLE);
  assign c_busy_rst    = 1'b0;
`endif

  always_ff @(posedge dac_clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_word  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_busy  <= c_busy_rst;
    end else begin
      r_state <= w_next;
      r_ptr   <= w_ptr_nxt;
      r_busy  <= w_busy_nxt;
      if (w_load) begin
        r_word <= w_word_d;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + c_cnt_w'(1);
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_ready   = w_ready;
  assign spi_word_o  = r_word;
  assign spi_start_o = w_start;
  assign busy_o      = r_busy;
  assign err_o       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dac_cmd_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_dac_cmd_arbiter                                           |
// | Description : Directed self-checking bench for dac_cmd_arbiter.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_dac_cmd_arbiter;

  logic        dac_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_ch = '0;
  logic [63:0] req_code = '0;
  logic [3:0]  req_ready;
  logic [23:0] spi_word_o;
  logic        spi_start_o;
  logic        spi_busy_i = 1'b0;
  logic        spi_done_i = 1'b0;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int bad = 0;

  always #5 dac_clk = ~dac_clk;

  dac_cmd_arbiter #(
    .NUM_REQ(4), .CH_W(4), .CODE_W(16), .CMD_WR(4'b0011),
    .SETTLE_CYC(8), .TIMEOUT_CYC(1024)
  ) u_dut (
    .dac_clk(dac_clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ch(req_ch),
    .req_code(req_code),
    .req_ready(req_ready),
    .spi_word_o(spi_word_o),
    .spi_start_o(spi_start_o),
    .spi_busy_i(spi_busy_i),
    .spi_done_i(spi_done_i),
    .busy_o(busy_o),
    .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge dac_clk);
      #1;
    end
  endtask

  initial begin
    logic [23:0] exp_w;
    int          e;

    // Reset state
    step(2);
    check("rst_ready", req_ready, 0);
    check("rst_start", spi_start_o, 0);
    check("rst_word", spi_word_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);

    // Single request from requester 2
    rst_n = 1'b1;
    req_valid = 4'b0100;
    req_ch[8 +: 4] = 4'd3;
    req_code[32 +: 16] = 16'hABCD;
    #1;
    check("single_ready", req_ready, 4'b0100);
    check("single_nostart", spi_start_o, 0);
    step(1);
    req_valid = '0;
    check("single_ready_off", req_ready, 0);
    check("single_word", spi_word_o, 24'h33ABCD);
    check("single_start", spi_start_o, 1);
    check("single_busy", busy_o, 1);
    step(1);
    check("single_start_once", spi_start_o, 0);
    spi_done_i = 1'b1;
    step(1);
    spi_done_i = 1'b0;
    step(7);
    check("single_settle_busy", busy_o, 1);
    step(1);
    check("single_idle", busy_o, 0);

    // Contention: all four requesters held high after a fresh reset
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    req_ch = 16'h3210;
    req_code = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      exp_w = {4'h3, e[3:0], 16'h1000 + e[15:0]};
      check("rr_grant", req_ready, 32'd1 << e);
      step(1);
      check("rr_word", spi_word_o, exp_w);
      check("rr_start", spi_start_o, 1);
      step(1);
      spi_done_i = 1'b1;
      step(1);
      spi_done_i = 1'b0;
      step(7);
      check("rr_gap", req_ready, 0);
      step(1);
    end
    req_valid = '0;
    #1;
    check("rr_drop", req_ready, 0);

    // Busy hold: pointer is now 1, requester 1 wins
    spi_busy_i = 1'b1;
    req_valid = 4'b0010;
    #1;
    check("bh_ready", req_ready, 4'b0010);
    step(1);
    req_valid = '0;
    check("bh_hold0", spi_start_o, 0);
    check("bh_word", spi_word_o, 24'h311001);
    for (int k = 0; k < 19; k++) begin
      step(1);
      check("bh_hold", spi_start_o, 0);
    end
    spi_busy_i = 1'b0;
    #1;
    check("bh_start", spi_start_o, 1);
    step(1);
    check("bh_single_pulse", spi_start_o, 0);
    spi_done_i = 1'b1;
    step(1);
    spi_done_i = 1'b0;
    step(8);
    check("bh_idle", busy_o, 0);

    // Timeout: pointer is 2, requester 0 wins via wrap
    req_valid = 4'b0001;
    #1;
    check("to_wrap_ready", req_ready, 4'b0001);
    step(1);
    req_valid = '0;
    check("to_start", spi_start_o, 1);
    check("to_word", spi_word_o, 24'h301000);
    step(1);
    step(1023);
    check("to_err_before", err_o, 0);
    check("to_busy_before", busy_o, 1);
    step(1);
    check("to_err_set", err_o, 1);
    check("to_idle", busy_o, 0);

    // Next request still served, error remains sticky
    req_valid = 4'b0010;
    #1;
    check("post_to_ready", req_ready, 4'b0010);
    step(1);
    req_valid = '0;
    check("post_to_word", spi_word_o, 24'h311001);
    check("post_to_start", spi_start_o, 1);
    check("err_sticky", err_o, 1);
    step(1);

    // Reset mid-frame in WAIT_DONE
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_start", spi_start_o, 0);
    check("mid_rst_word", spi_word_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_err", err_o, 0);
    spi_done_i = 1'b1;
    step(1);
    spi_done_i = 1'b0;
    check("late_done_busy", busy_o, 0);
    check("late_done_start", spi_start_o, 0);
    req_valid = 4'b1001;
    #1;
    check("ptr_reset", req_ready, 4'b0001);
    req_valid = '0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
